// File: rtl/scariv_ldq_ptr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : scariv_ldq_ptr_ctrl
//  Purpose  : Pointer / occupancy control for the load queue (LDQ).
//             Allocates up to DISP_NUM entries per cycle in program order and
//             retires at most one entry per cycle, strictly in order, from
//             the oldest live entry.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_clk              clock, rising edge
//    i_reset_n          asynchronous active-low reset
//    i_disp_valid       per-slot dispatch request
//    o_disp_ready       all DISP_NUM slots can be accepted this cycle
//    o_disp_entry_oh    per-slot one-hot of the allocated entry
//    o_entry_load       per-entry allocation strobe (OR of all slots)
//    i_entry_finish     per-entry finish; only the oldest entry is honoured
//    o_outptr_valid_oh  one-hot of the oldest live entry, zero when empty
//    o_inptr/o_outptr   pointers including wrap bit
//    o_count/o_empty/o_full  occupancy
//    o_max_count/o_stall_cycles  statistics
//  Configuration
//    SCARIV_LDQ_PTR_STAT_EN : when defined, statistics registers are built;
//                             otherwise the statistics outputs are tied to 0.
// ============================================================================
module scariv_ldq_ptr_ctrl #(
  parameter int ENTRY_NUM = 16,
  parameter int DISP_NUM  = 2
) (
  input  logic                            i_clk,
  input  logic                            i_reset_n,
  input  logic [DISP_NUM-1:0]             i_disp_valid,
  output logic                            o_disp_ready,
  output logic [DISP_NUM*ENTRY_NUM-1:0]   o_disp_entry_oh,
  output logic [ENTRY_NUM-1:0]            o_entry_load,
  input  logic [ENTRY_NUM-1:0]            i_entry_finish,
  output logic [ENTRY_NUM-1:0]            o_outptr_valid_oh,
  output logic [$clog2(ENTRY_NUM):0]      o_inptr,
  output logic [$clog2(ENTRY_NUM):0]      o_outptr,
  output logic [$clog2(ENTRY_NUM):0]      o_count,
  output logic                            o_empty,
  output logic                            o_full,
  output logic [$clog2(ENTRY_NUM):0]      o_max_count,
  output logic [31:0]                     o_stall_cycles
);

  localparam int IDX_W = $clog2(ENTRY_NUM);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [ENTRY_NUM-1:0] C_ONE_OH = {{(ENTRY_NUM-1){1'b0}}, 1'b1};

  logic [PTR_W-1:0]             inptr_q;
  logic [PTR_W-1:0]             outptr_q;
  logic [PTR_W-1:0]             inptr_d;
  logic [PTR_W-1:0]             outptr_d;

  logic [IDX_W-1:0]             w_in_idx;
  logic [IDX_W-1:0]             w_out_idx;
  logic [PTR_W-1:0]             w_count;
  logic                         w_empty;
  logic                         w_full;
  logic                         w_ready;
  logic [PTR_W-1:0]             w_valid_cnt;
  logic [PTR_W-1:0]             w_acc_cnt;
  logic                         w_retire;
  logic [DISP_NUM*ENTRY_NUM-1:0] w_disp_oh;
  logic [ENTRY_NUM-1:0]         w_entry_load;

  assign w_in_idx  = inptr_q[IDX_W-1:0];
  assign w_out_idx = outptr_q[IDX_W-1:0];

  // Pointer difference modulo 2*ENTRY_NUM yields 0..ENTRY_NUM directly.
  assign w_count = inptr_q - outptr_q;
  assign w_empty = (inptr_q == outptr_q);
  assign w_full  = (w_in_idx == w_out_idx) && (inptr_q[IDX_W] != outptr_q[IDX_W]);

  // Readiness is all-or-nothing and ignores a retire in the same cycle, so
  // the check stays off the finish path.
  assign w_ready = ((32'(w_count) + 32'(DISP_NUM)) <= 32'(ENTRY_NUM));

  // Each valid slot takes the next free entry after all lower valid slots;
  // invalid slots do not consume an entry.
  always_comb begin
    logic [PTR_W-1:0] offset;
    logic [IDX_W-1:0] slot_idx;
    offset       = '0;
    slot_idx     = '0;
    w_disp_oh    = '0;
    w_entry_load = '0;
    for (int k = 0; k < DISP_NUM; k++) begin
      slot_idx = w_in_idx + offset[IDX_W-1:0];
      if (i_disp_valid[k] && w_ready) begin
        w_disp_oh[k*ENTRY_NUM +: ENTRY_NUM] = C_ONE_OH << slot_idx;
        w_entry_load = w_entry_load | (C_ONE_OH << slot_idx);
      end
      if (i_disp_valid[k]) begin
        offset = offset + PTR_W'(1);
      end
    end
    w_valid_cnt = offset;
  end

  assign w_acc_cnt = w_ready ? w_valid_cnt : '0;

  // Only the oldest entry can retire; finish bits elsewhere are ignored.
  assign w_retire = !w_empty && i_entry_finish[w_out_idx];

  assign inptr_d  = inptr_q + w_acc_cnt;
  assign outptr_d = outptr_q + {{(PTR_W-1){1'b0}}, w_retire};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      inptr_q  <= '0;
      outptr_q <= '0;
    end else begin
      inptr_q  <= inptr_d;
      outptr_q <= outptr_d;
    end
  end

`ifdef SCARIV_LDQ_PTR_STAT_EN
  logic [PTR_W-1:0] max_count_q;
  logic [31:0]      stall_q;
  logic [PTR_W-1:0] w_count_next;

  assign w_count_next = inptr_d - outptr_d;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      max_count_q <= '0;
      stall_q     <= '0;
    end else begin
      if (w_count_next > max_count_q) begin
        max_count_q <= w_count_next;
      end
      if ((|i_disp_valid) && !w_ready && (stall_q != 32'hFFFF_FFFF)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign o_max_count    = max_count_q;
  assign o_stall_cycles = stall_q;
`else
  assign o_max_count    = '0;
  assign o_stall_cycles = '0;
`endif

  assign o_disp_ready      = w_ready;
  assign o_disp_entry_oh   = w_disp_oh;
  assign o_entry_load      = w_entry_load;
  assign o_outptr_valid_oh = w_empty ? '0 : (C_ONE_OH << w_out_idx);
  assign o_inptr           = inptr_q;
  assign o_outptr          = outptr_q;
  assign o_count           = w_count;
  assign o_empty           = w_empty;
  assign o_full            = w_full;

endmodule
`default_nettype wire

// File: doc/scariv_ldq_ptr_ctrl.md
SCARIV_LDQ_PTR_CTRL -- requirements
Module: scariv_ldq_ptr_ctrl

Interface
REQ-001 SHALL have parameter ENTRY_NUM, default 16, LDQ entry count, power of two, >=4.
REQ-002 SHALL have parameter DISP_NUM, default 2, load dispatch slots per cycle, 1..4, <=ENTRY_NUM/2.
REQ-003 SHALL have port i_clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port i_reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_disp_valid  input  DISP_NUM  per-slot load dispatch request; any bit pattern legal.
REQ-006 SHALL have port o_disp_ready  output  1  queue can accept all DISP_NUM slots this cycle.
REQ-007 SHALL have port o_disp_entry_oh  output  DISP_NUM*ENTRY_NUM  per-slot one-hot of the allocated entry index.
REQ-008 SHALL have port o_entry_load  output  ENTRY_NUM  per-entry dispatch-load strobe.
REQ-009 SHALL have port i_entry_finish  input  ENTRY_NUM  per-entry finish (committed or dead, and outptr-valid seen).
REQ-010 SHALL have port o_outptr_valid_oh  output  ENTRY_NUM  one-hot of the oldest live entry, zero when empty.
REQ-011 SHALL have ports o_inptr and o_outptr  output  log2(ENTRY_NUM)+1  pointers including the wrap bit.
REQ-012 SHALL have ports o_count  output  log2(ENTRY_NUM)+1  occupancy; o_empty and o_full  output  1 each.
REQ-013 SHALL have ports o_max_count  output  log2(ENTRY_NUM)+1 and o_stall_cycles  output  32  statistics (REQ-030).

Function
REQ-014 SHALL compute accept[k] = i_disp_valid[k] & o_disp_ready, combinationally.
REQ-015 SHALL assign slot k the entry (inptr + popcount(i_disp_valid[k-1:0])) mod ENTRY_NUM; o_disp_entry_oh[k] = 0 when accept[k] = 0.
REQ-016 SHALL drive o_entry_load as the bitwise OR of all o_disp_entry_oh slots; same cycle as accept; zero-latency.
REQ-017 SHALL drive o_disp_ready = (o_count + DISP_NUM <= ENTRY_NUM); the same-cycle retire SHALL NOT be credited.
REQ-018 SHALL advance inptr by popcount(accept) at the next edge, modulo 2*ENTRY_NUM (wrap bit toggles on index wrap).
REQ-019 SHALL drive o_outptr_valid_oh = one-hot(outptr index) when !o_empty, else 0.
REQ-020 SHALL retire at most one entry per cycle: retire = !o_empty & i_entry_finish[outptr index]; outptr +1 at next edge.
REQ-021 SHALL ignore i_entry_finish bits at non-outptr indices and all bits when empty.
REQ-022 SHALL update count_next = count + popcount(accept) - retire; simultaneous allocate and retire both take effect.
REQ-023 SHALL drive o_empty = (inptr == outptr) and o_full = (index equal & wrap bits differ); o_count equals the pointer difference.
REQ-024 SHALL keep retirement in order: an entry is never re-allocated before it retires, since ready excludes occupied entries.

Reset
REQ-025 SHALL on i_reset_n low asynchronously clear inptr, outptr, count, o_max_count and o_stall_cycles to 0.
REQ-026 SHALL while in reset drive o_empty=1, o_full=0, o_disp_ready=1, o_outptr_valid_oh=0.
REQ-026a SHALL also drive o_entry_load and o_disp_entry_oh combinationally from i_disp_valid while in reset; the dispatch stage treats them as don't-care until reset deasserts.
REQ-027 SHALL discard any in-flight allocation when reset asserts mid-cycle; no partial pointer update.

Configuration
REQ-028 SHALL gate statistics with macro SCARIV_LDQ_PTR_STAT_EN.
REQ-029 SHALL, with the macro defined, register o_max_count = max(o_max_count, count_next) each cycle, and increment o_stall_cycles (saturating at 2^32-1) in every cycle with |i_disp_valid & !o_disp_ready.
REQ-030 SHALL, without the macro, tie o_max_count and o_stall_cycles to 0 and instantiate no statistics flops; ports remain present.

Verification
REQ-031 SHALL cover: reset, i_disp_valid=2'b11 -> o_disp_entry_oh slot0=entry0, slot1=entry1; next cycle o_count=2, o_outptr_valid_oh=0x0001.
REQ-032 SHALL cover: i_disp_valid=2'b10 at inptr=5 -> slot1 gets entry 5 and slot0 gets none; inptr becomes 6.
REQ-033 SHALL cover: count=14, i_disp_valid=2'b01 -> o_disp_ready=1; count=15 -> o_disp_ready=0, no o_entry_load, and with STAT_EN o_stall_cycles increments by 1.
REQ-034 SHALL cover: count=15 with i_entry_finish at the outptr entry and i_disp_valid=2'b11 in the same cycle -> no allocation; count becomes 14.
REQ-035 SHALL cover: 40 alloc/retire cycles through wrap -> inptr index wraps 15->0 with the wrap bit toggled, o_full=1 exactly at count 16, and ordering preserved.
REQ-036 SHALL cover: i_entry_finish=0x0008 while outptr=2 -> ignored; then 0x0004 -> outptr becomes 3 and o_outptr_valid_oh=0x0008.
